// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Holds the FSM state encoding and the bit positions inside the registered flags word.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_CAPT = 3'd4,
    S_SHOW = 3'd5
  } state_t;

  localparam int FLG_NEG   = 3;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVER  = 0;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer plus an edge register for an asynchronous button.
// Produces a single-cycle pulse per press, however long the button is held.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse_o
);

  logic s1_q, s2_q, s3_q;

  // Synchronizer chain and edge-detect register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps the operator through operand A, operand B and the operation, one button press each,
// then captures the combinational ALU result and flags and counts completed executions.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     data_in,
  input  logic [2:0]       op_in,
  input  logic [1:0]       mode_in,
  input  logic             btn_next,
  input  logic             clear,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_neg,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_over,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_op_sum,
  output logic             alu_op_subt,
  output logic [N-1:0]     res_q,
  output logic [3:0]       flags_q,
  output logic             res_valid,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] exec_count
);

  state_t             state_q, state_d;
  logic [N-1:0]       a_q, a_d, b_q, b_d, res_r_q, res_d;
  logic [2:0]         op_q, op_d;
  logic [1:0]         mode_q, mode_d;
  logic [3:0]         flags_r_q, flags_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               nxt;

  btn_edge_sync u_btn (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (btn_next),
    .pulse_o  (nxt)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 3'd0;
      mode_q    <= 2'd0;
      res_r_q   <= '0;
      flags_r_q <= 4'd0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      mode_q    <= mode_d;
      res_r_q   <= res_d;
      flags_r_q <= flags_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and capture logic; clear overrides everything except the counter.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    mode_d  = mode_q;
    res_d   = res_r_q;
    flags_d = flags_r_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_A: begin
        if (nxt) begin
          a_d     = data_in;
          state_d = S_B;
        end else begin
          state_d = S_A;
        end
      end
      S_B: begin
        if (nxt) begin
          b_d     = data_in;
          state_d = S_OP;
        end else begin
          state_d = S_B;
        end
      end
      S_OP: begin
        if (nxt) begin
          op_d    = op_in;
          mode_d  = mode_in;
          state_d = S_EXEC;
        end else begin
          state_d = S_OP;
        end
      end
      S_EXEC: state_d = S_CAPT;
      S_CAPT: begin
        res_d              = alu_result;
        flags_d[FLG_NEG]   = alu_neg;
        flags_d[FLG_ZERO]  = alu_zero;
        flags_d[FLG_CARRY] = alu_carry;
        flags_d[FLG_OVER]  = alu_over;
        valid_d            = 1'b1;
        cnt_d              = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d            = S_SHOW;
      end
      S_SHOW: begin
        if (nxt) begin
          state_d = S_A;
        end else begin
          state_d = S_SHOW;
        end
      end
      default: state_d = S_A;
    endcase
    if (clear) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = 3'd0;
      mode_d  = 2'd0;
      res_d   = '0;
      flags_d = 4'd0;
      valid_d = 1'b0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign alu_op_sum  = mode_q[1];
  assign alu_op_subt = mode_q[0];
  assign res_q       = res_r_q;
  assign flags_q     = flags_r_q;
  assign res_valid   = valid_q;
  assign state_o     = state_q;
  assign exec_count  = cnt_q;

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Drives the ALU from the operator side: captures operand A, operand B and the operation from board switches, one btn_next press per step.
- Presents the captured values to the ALU, then registers the ALU result and flags for display and logging.
- Sits between the switch/button inputs and the combinational ALU in the lab top level.

Parameters:
- N, 4, operand/result width; matches the ALU's N.
- CNT_W, 8, width of the completed-execution counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  N  operand switches
- op_in  in  3  op select switches (ALU op code)
- mode_in  in  2  {op_sum, op_subt} switches
- btn_next  in  1  advance button, asynchronous, level
- clear  in  1  synchronous clear, active-high, already synchronous to clk
- alu_result  in  N  ALU result
- alu_neg, alu_zero, alu_carry, alu_over  in  1 each  ALU flags
- alu_a, alu_b  out  N  operands to ALU
- alu_op  out  3  op to ALU
- alu_op_sum, alu_op_subt  out  1 each  add/sub selects to ALU
- res_q  out  N  registered result
- flags_q  out  4  registered {neg, zero, carry, over}
- res_valid  out  1  res_q holds a completed execution
- state_o  out  3  current FSM state code
- exec_count  out  CNT_W  completed executions, wraps

Behaviour:
- Reset (rst_n=0, async):
  - all outputs and registers are 0; state is S_A.
  - synchronizer flops reset to 0, so a button held through reset does not produce an edge.
- Button: btn_next passes through a 2-flop synchronizer plus an edge register; nxt = s2 & ~s3.
  - One nxt pulse per press, regardless of hold length.
  - Action occurs on the 3rd rising clk edge after btn_next is first sampled high.
- FSM states:
  - S_A=0: on nxt, alu_a <= data_in; go to S_B.
  - S_B=1: on nxt, alu_b <= data_in; go to S_OP.
  - S_OP=2: on nxt, alu_op <= op_in and {alu_op_sum, alu_op_subt} <= mode_in; go to S_EXEC.
  - S_EXEC=3: one cycle for the ALU to settle; unconditionally go to S_CAPT.
  - S_CAPT=4, one cycle:
    - res_q <= alu_result; flags_q <= {alu_neg, alu_zero, alu_carry, alu_over}.
    - res_valid <= 1; exec_count <= exec_count + 1 (modulo 2^CNT_W); go to S_SHOW.
  - S_SHOW=5: hold; on nxt go to S_A.
    - res_q, flags_q and res_valid hold until the next S_CAPT.
    - alu_a, alu_b, alu_op and the mode selects are not cleared.
- Latency: ALU result is registered exactly 2 cycles after the S_OP capture edge.
- nxt during S_EXEC or S_CAPT is dropped, not queued.
- mode_in values 00 and 11 pass through unchanged; the ALU then selects the logic path. The sequencer does not interpret op codes.
- clear=1 (synchronous, highest priority after reset):
  - state <= S_A; alu_a, alu_b, alu_op, mode selects, res_q, flags_q and res_valid <= 0.
  - exec_count is preserved.
  - A simultaneous nxt is ignored.
- Reset asserted mid-operation: everything returns to reset values immediately, including exec_count.
- Unused state codes 6 and 7 go to S_A on the next edge.
- ALU outputs change only on a capture edge and are stable for the whole of S_EXEC and S_CAPT.

Decomposition:
- Package alu_seq_pkg:
  - state_t enum (S_A..S_SHOW, 3-bit).
  - Flag index constants: FLG_NEG=3, FLG_ZERO=2, FLG_CARRY=1, FLG_OVER=0.
- Sub-module btn_edge_sync: clk, rst_n, async_in -> 1-cycle pulse. Reusable for other lab buttons.
- FSM, operand registers and counter stay in alu_operand_sequencer.

Test Plan:
- Add, with N=4 and the real ALU attached: press sequence with data_in=3, then 5, then mode_in=10 -> res_q=4'h8, flags_q[FLG_ZERO]=0, res_valid=1, exec_count=1, state_o=5.
- Subtract: A=3, B=5, mode_in=01 -> res_q=4'hE, flags_q[FLG_NEG]=1; A=5, B=5 -> res_q=0, flags_q[FLG_ZERO]=1.
- Held button: btn_next high for 50 cycles in S_A -> exactly one advance (state_o 0->1); release and re-press -> state_o=2.
- Clear in S_OP with exec_count=2 -> state_o=0, alu_a=alu_b=0, res_valid=0, exec_count=2; clear and nxt in the same cycle -> state_o stays 0.
- Async reset pulse mid-S_EXEC, between clock edges -> all outputs 0 immediately; no capture occurs after release.
- Wrap: 256 full sequences with CNT_W=8 -> exec_count returns to 0; press during S_EXEC -> ignored, FSM reaches S_SHOW and waits.
